// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage.
//   MEMRW_*  : memory operation field from EX/MEM
//   DSIZE_*  : access size field from EX/MEM (2'b11 behaves as a word)
//   state_t  : handshake FSM states
//   cnt_width: bit width of the no-ack timeout counter
package mem_pkg;

    localparam logic [1:0] MEMRW_NONE  = 2'b00;
    localparam logic [1:0] MEMRW_LOAD  = 2'b01;
    localparam logic [1:0] MEMRW_STORE = 2'b10;

    localparam logic [1:0] DSIZE_B = 2'b00;
    localparam logic [1:0] DSIZE_H = 2'b01;
    localparam logic [1:0] DSIZE_W = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // The counter has to be able to hold the value timeout_cyc itself.
    function automatic int cnt_width(input int timeout_cyc);
        return $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/mem_access_load_extract.sv
// Load data extraction: selects the byte/half at the byte offset of the
// read word and sign- or zero-extends it. Word accesses pass through.
// Purely combinational so the forwarding path can reuse it.
//   i_rdata    : 32-bit word read from memory
//   i_ofs      : byte offset addr[1:0]
//   i_size     : DSIZE_B / DSIZE_H / word
//   i_unsigned : 1 = zero-extend (LBU/LHU)
//   o_data     : extended 32-bit load result
module load_extract
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_ofs,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_ofs, 3'b000} +: 8];
    // Halfwords are only ever extracted aligned, so ofs[0] does not matter.
    assign w_half = i_rdata[{i_ofs[1], 4'b0000} +: 16];

    always_comb begin
        o_data = i_rdata;
        case (i_size)
            DSIZE_B: o_data = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
            DSIZE_H: o_data = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage of the RV32I pipeline: req/ack handshake to data memory with
// store lane placement, load extraction, misalign detection and a no-ack
// timeout. Drives the MEM/WB register and the upstream stall.
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid, *_pype2           : EX/MEM register fields
//   dmem_*                      : data memory request/response
//   stall                       : hold EX/MEM while an access is outstanding
//   *_pype3                     : MEM/WB register fields
//   misalign_err, bus_err       : one-cycle error pulses
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access outstanding; EX/MEM sampled every cycle
// ST_WAIT | request on the bus, fields latched, waiting for dmem_ack
module mem_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] ALU_co_pype,
    input  logic [31:0] read_data2_pype2,
    input  logic [1:0]  dsize_pype2,
    input  logic [1:0]  MemRW_pype2,
    input  logic [2:0]  funct3_pype2,
    input  logic [4:0]  WReg_pype2,
    input  logic        RegWrite_pype2,
    input  logic [1:0]  MemtoReg_pype2,
    input  logic [31:0] PCp4_pype2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] load_data_pype3,
    output logic [31:0] ALU_co_pype3,
    output logic [31:0] PCp4_pype3,
    output logic [4:0]  WReg_pype3,
    output logic        RegWrite_pype3,
    output logic [1:0]  MemtoReg_pype3,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int CNT_W = cnt_width(TIMEOUT_CYC);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;

    logic        r_we, r_uns, r_regwrite;
    logic [31:0] r_addr, r_wdata, r_pcp4;
    logic [3:0]  r_be;
    logic [1:0]  r_size, r_memtoreg;
    logic [4:0]  r_wreg;

    logic        w_mem_op, w_is_byte, w_is_half, w_misaligned;
    logic        w_accept, w_done, w_abort;
    logic [1:0]  w_ofs;
    logic [3:0]  w_be_lane;
    logic [31:0] w_wdata_lane, w_ext;
    logic        w_unused;

    assign w_unused     = ^funct3_pype2[1:0];
    assign w_ofs        = ALU_co_pype[1:0];
    assign w_mem_op     = in_valid & ((MemRW_pype2 == MEMRW_LOAD) | (MemRW_pype2 == MEMRW_STORE));
    assign w_is_byte    = (dsize_pype2 == DSIZE_B);
    assign w_is_half    = (dsize_pype2 == DSIZE_H);
    assign w_misaligned = (w_is_half & w_ofs[0]) | (!w_is_byte & !w_is_half & (w_ofs != 2'b00));

    always_comb begin
        w_be_lane    = 4'b1111;
        w_wdata_lane = read_data2_pype2;
        if (w_is_byte) begin
            w_be_lane    = 4'b0001 << w_ofs;
            w_wdata_lane = {4{read_data2_pype2[7:0]}};
        end else if (w_is_half) begin
            w_be_lane    = 4'b0011 << w_ofs;
            w_wdata_lane = {2{read_data2_pype2[15:0]}};
        end
    end

    load_extract u_load_extract (
        .i_rdata    (dmem_rdata),
        .i_ofs      (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        dmem_req    = 1'b0;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_op && !w_misaligned) begin
                    w_accept    = 1'b1;
                    stall       = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                dmem_req = 1'b1;
                stall    = !dmem_ack;
                if (dmem_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // This no-ack cycle is the TIMEOUT_CYC-th one.
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign dmem_we    = r_we;
    assign dmem_addr  = {r_addr[31:2], 2'b00};
    assign dmem_be    = r_be;
    assign dmem_wdata = r_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt           <= '0;
            r_we            <= 1'b0;
            r_uns           <= 1'b0;
            r_regwrite      <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_pcp4          <= '0;
            r_be            <= '0;
            r_size          <= '0;
            r_memtoreg      <= '0;
            r_wreg          <= '0;
            load_data_pype3 <= '0;
            ALU_co_pype3    <= '0;
            PCp4_pype3      <= '0;
            WReg_pype3      <= '0;
            RegWrite_pype3  <= 1'b0;
            MemtoReg_pype3  <= '0;
            misalign_err    <= 1'b0;
            bus_err         <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_accept) begin
                    r_we           <= (MemRW_pype2 == MEMRW_STORE);
                    r_addr         <= ALU_co_pype;
                    r_be           <= w_be_lane;
                    r_wdata        <= w_wdata_lane;
                    r_size         <= dsize_pype2;
                    r_uns          <= funct3_pype2[2];
                    r_regwrite     <= RegWrite_pype2;
                    r_wreg         <= WReg_pype2;
                    r_memtoreg     <= MemtoReg_pype2;
                    r_pcp4         <= PCp4_pype2;
                    r_cnt          <= '0;
                    RegWrite_pype3 <= 1'b0;
                end else begin
                    // Plain ALU op, bubble, or a misaligned access turned into a bubble.
                    load_data_pype3 <= '0;
                    ALU_co_pype3    <= ALU_co_pype;
                    PCp4_pype3      <= PCp4_pype2;
                    WReg_pype3      <= WReg_pype2;
                    MemtoReg_pype3  <= MemtoReg_pype2;
                    RegWrite_pype3  <= RegWrite_pype2 & in_valid & !w_mem_op;
                    misalign_err    <= w_mem_op;
                end
            end else begin
                RegWrite_pype3 <= 1'b0;
                if (w_done) begin
                    load_data_pype3 <= r_we ? 32'b0 : w_ext;
                    ALU_co_pype3    <= r_addr;
                    PCp4_pype3      <= r_pcp4;
                    WReg_pype3      <= r_wreg;
                    MemtoReg_pype3  <= r_memtoreg;
                    RegWrite_pype3  <= r_regwrite;
                    r_cnt           <= '0;
                end else if (w_abort) begin
                    bus_err <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] ALU_co_pype, read_data2_pype2, PCp4_pype2;
    logic [1:0]  dsize_pype2, MemRW_pype2, MemtoReg_pype2;
    logic [2:0]  funct3_pype2;
    logic [4:0]  WReg_pype2;
    logic        RegWrite_pype2;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        stall;
    logic [31:0] load_data_pype3, ALU_co_pype3, PCp4_pype3;
    logic [4:0]  WReg_pype3;
    logic        RegWrite_pype3;
    logic [1:0]  MemtoReg_pype3;
    logic        misalign_err, bus_err;

    int n_vec = 0;
    int n_err = 0;

    int          req_cyc, stall_cyc;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT_CYC(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .ALU_co_pype      (ALU_co_pype),
        .read_data2_pype2 (read_data2_pype2),
        .dsize_pype2      (dsize_pype2),
        .MemRW_pype2      (MemRW_pype2),
        .funct3_pype2     (funct3_pype2),
        .WReg_pype2       (WReg_pype2),
        .RegWrite_pype2   (RegWrite_pype2),
        .MemtoReg_pype2   (MemtoReg_pype2),
        .PCp4_pype2       (PCp4_pype2),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_be          (dmem_be),
        .dmem_wdata       (dmem_wdata),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .stall            (stall),
        .load_data_pype3  (load_data_pype3),
        .ALU_co_pype3     (ALU_co_pype3),
        .PCp4_pype3       (PCp4_pype3),
        .WReg_pype3       (WReg_pype3),
        .RegWrite_pype3   (RegWrite_pype3),
        .MemtoReg_pype3   (MemtoReg_pype3),
        .misalign_err     (misalign_err),
        .bus_err          (bus_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] rw, input logic [1:0] sz,
                         input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] wreg, input logic regw);
        in_valid         = v;
        MemRW_pype2      = rw;
        dsize_pype2      = sz;
        funct3_pype2     = f3;
        ALU_co_pype      = addr;
        read_data2_pype2 = wd;
        WReg_pype2       = wreg;
        RegWrite_pype2   = regw;
        MemtoReg_pype2   = 2'b01;
        PCp4_pype2       = addr + 32'd4;
    endtask

    task automatic idle_in();
        drive(1'b0, 2'b00, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
        dmem_ack = 1'b0;
    endtask

    // Called at posedge+1. Presents one op, acks on WAIT cycle ack_at
    // (0 = never), returns at posedge+1 of the first cycle after the
    // request is gone with the bus idle again.
    task automatic mem_txn(input logic [1:0] rw, input logic [1:0] sz, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                           input logic [4:0] wreg, input logic regw, input int ack_at);
        int  wc;
        bit  ended;
        wc = 0;
        ended = 1'b0;
        req_cyc = 0;
        stall_cyc = 0;
        cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
        drive(1'b1, rw, sz, f3, addr, wd, wreg, regw);
        dmem_rdata = rdata;
        dmem_ack = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (!dmem_req) begin
                    ended = 1'b1;
                    break;
                end
            end
            if (dmem_req) begin
                wc++;
                // Scramble the held inputs: the stage must use its latched copy.
                ALU_co_pype      = ~addr;
                read_data2_pype2 = ~wd;
                dsize_pype2      = ~sz;
            end
            dmem_ack = dmem_req && (ack_at != 0) && (wc == ack_at);
            @(negedge clk);
            if (stall) stall_cyc++;
            if (dmem_req) begin
                req_cyc++;
                if (wc == 1) begin
                    cap_addr = dmem_addr; cap_wdata = dmem_wdata;
                    cap_be = dmem_be; cap_we = dmem_we;
                end
            end
        end
        check_eq("txn_completes", 32'(ended), 32'd1);
        idle_in();
    endtask

    initial begin
        rst = 1'b1;
        dmem_rdata = '0;
        idle_in();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_req", 32'(dmem_req), 0);
        check_eq("rst_stall", 32'(stall), 0);
        check_eq("rst_alu", ALU_co_pype3, 0);
        check_eq("rst_regwr", 32'(RegWrite_pype3), 0);
        check_eq("rst_errs", {30'b0, misalign_err, bus_err}, 0);

        // SW 0xDEADBEEF -> 0x100, ack on 2nd WAIT cycle
        @(posedge clk); #1;
        mem_txn(2'b10, 2'b10, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 5'd0, 1'b0, 2);
        @(negedge clk);
        check_eq("sw_req_cyc", 32'(req_cyc), 2);
        check_eq("sw_stall_cyc", 32'(stall_cyc), 2);
        check_eq("sw_addr", cap_addr, 32'h100);
        check_eq("sw_be", 32'(cap_be), 32'hF);
        check_eq("sw_wdata", cap_wdata, 32'hDEADBEEF);
        check_eq("sw_we", 32'(cap_we), 1);
        check_eq("sw_regwr", 32'(RegWrite_pype3), 0);
        check_eq("sw_ldata", load_data_pype3, 0);

        // SB 0xAB -> 0x103, immediate ack
        @(posedge clk); #1;
        mem_txn(2'b10, 2'b00, 3'b000, 32'h103, 32'h000000AB, 32'h0, 5'd0, 1'b0, 1);
        @(negedge clk);
        check_eq("sb_be", 32'(cap_be), 32'h8);
        check_eq("sb_addr", cap_addr, 32'h100);
        check_eq("sb_wdata", cap_wdata, 32'hABABABAB);
        check_eq("sb_stall_cyc", 32'(stall_cyc), 1);
        check_eq("sb_req_cyc", 32'(req_cyc), 1);

        // LB 0x102, rdata 0x00800000 -> sign-extended 0x80
        @(posedge clk); #1;
        mem_txn(2'b01, 2'b00, 3'b000, 32'h102, 32'h0, 32'h00800000, 5'd7, 1'b1, 1);
        @(negedge clk);
        check_eq("lb_data", load_data_pype3, 32'hFFFFFF80);
        check_eq("lb_we", 32'(cap_we), 0);
        check_eq("lb_addr", cap_addr, 32'h100);
        check_eq("lb_regwr", 32'(RegWrite_pype3), 1);
        check_eq("lb_wreg", 32'(WReg_pype3), 7);
        check_eq("lb_alu", ALU_co_pype3, 32'h102);
        check_eq("lb_pcp4", PCp4_pype3, 32'h106);
        check_eq("lb_m2r", 32'(MemtoReg_pype3), 1);

        // LBU same location
        @(posedge clk); #1;
        mem_txn(2'b01, 2'b00, 3'b100, 32'h102, 32'h0, 32'h00800000, 5'd7, 1'b1, 1);
        @(negedge clk);
        check_eq("lbu_data", load_data_pype3, 32'h00000080);

        // LH 0x102, rdata 0x80010000, ack on 3rd WAIT cycle
        @(posedge clk); #1;
        mem_txn(2'b01, 2'b01, 3'b001, 32'h102, 32'h0, 32'h80010000, 5'd8, 1'b1, 3);
        @(negedge clk);
        check_eq("lh_data", load_data_pype3, 32'hFFFF8001);
        check_eq("lh_req_cyc", 32'(req_cyc), 3);

        // LW 0x101 misaligned
        @(posedge clk); #1;
        mem_txn(2'b01, 2'b10, 3'b010, 32'h101, 32'h0, 32'h12345678, 5'd9, 1'b1, 1);
        @(negedge clk);
        check_eq("mis_req_cyc", 32'(req_cyc), 0);
        check_eq("mis_stall_cyc", 32'(stall_cyc), 0);
        check_eq("mis_err", 32'(misalign_err), 1);
        check_eq("mis_regwr", 32'(RegWrite_pype3), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("mis_err_pulse", 32'(misalign_err), 0);

        // Load never acked -> timeout
        @(posedge clk); #1;
        mem_txn(2'b01, 2'b10, 3'b010, 32'h200, 32'h0, 32'h0, 5'd10, 1'b1, 0);
        @(negedge clk);
        check_eq("to_req_cyc", 32'(req_cyc), 16);
        check_eq("to_bus_err", 32'(bus_err), 1);
        check_eq("to_regwr", 32'(RegWrite_pype3), 0);
        check_eq("to_req_low", 32'(dmem_req), 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("to_bus_pulse", 32'(bus_err), 0);

        // ADD result (also proves the FSM is back in IDLE)
        @(posedge clk); #1;
        drive(1'b1, 2'b00, 2'b10, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1);
        @(negedge clk);
        check_eq("add_stall", 32'(stall), 0);
        @(posedge clk); #1;
        idle_in();
        @(negedge clk);
        check_eq("add_alu", ALU_co_pype3, 32'h1234);
        check_eq("add_wreg", 32'(WReg_pype3), 5);
        check_eq("add_regwr", 32'(RegWrite_pype3), 1);
        check_eq("add_ldata", load_data_pype3, 0);

        // Reset during WAIT
        @(posedge clk); #1;
        drive(1'b1, 2'b01, 2'b10, 3'b010, 32'h300, 32'h0, 5'd9, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("rw_req_before", 32'(dmem_req), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        dmem_ack = 1'b1;
        @(negedge clk);
        check_eq("rw_req_drop", 32'(dmem_req), 0);
        check_eq("rw_stall", 32'(stall), 0);
        check_eq("rw_regwr", 32'(RegWrite_pype3), 0);
        check_eq("rw_wreg", 32'(WReg_pype3), 0);
        check_eq("rw_alu", ALU_co_pype3, 0);
        check_eq("rw_addr", dmem_addr, 0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        check_eq("rw_idle_ack_regwr", 32'(RegWrite_pype3), 0);
        check_eq("rw_idle_ack_ldata", load_data_pype3, 0);
        check_eq("rw_idle_ack_req", 32'(dmem_req), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
MEM stage of the 5-stage RV32I pipeline. It consumes the EX/MEM register fields and runs a req/ack handshake to data memory. Byte and halfword stores are placed into lanes, and loads are extracted and sign- or zero-extended. The stage drives the MEM/WB register and a stall line, which feeds the upstream keep while a memory access is outstanding.

Parameters:
TIMEOUT_CYC, 16, max WAIT cycles without dmem_ack before the access is aborted with bus_err.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  EX/MEM entry valid (0 = bubble)
ALU_co_pype  in  32  ALU result / effective byte address
read_data2_pype2  in  32  store data, right-justified (low bytes valid)
dsize_pype2  in  2  00 byte, 01 half, 10 word; 11 treated as word
MemRW_pype2  in  2  00 none, 01 load, 10 store, 11 none
funct3_pype2  in  3  bit2=1 means unsigned load (LBU/LHU)
WReg_pype2  in  5  destination register
RegWrite_pype2  in  1  register write enable
MemtoReg_pype2  in  2  writeback select, passed through
PCp4_pype2  in  32  PC+4, passed through
dmem_req  out  1  request; held high until ack or abort
dmem_we  out  1  1 = write
dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-shifted store data
dmem_ack  in  1  access done; rdata valid the same cycle
dmem_rdata  in  32  read word
stall  out  1  combinational; upstream holds EX/MEM while high
load_data_pype3, ALU_co_pype3, PCp4_pype3  out  32  MEM/WB data
WReg_pype3  out  5; RegWrite_pype3  out  1; MemtoReg_pype3  out  2  MEM/WB control
misalign_err  out  1  one-cycle pulse
bus_err  out  1  one-cycle pulse

Behaviour:
- Reset values:
  - All outputs and registers are 0.
  - State is IDLE and the timeout counter is 0.
  - Reset taking effect mid-WAIT drops dmem_req on the next cycle, and no writeback occurs.
- States: IDLE and WAIT.
- Definitions:
  - mem_op = in_valid & (MemRW == 01 | MemRW == 10).
  - misaligned = (half & addr[0]) | (word & addr[1:0] != 0).
- IDLE:
  - Not mem_op: MEM/WB loads the inputs at the next edge (1-cycle latency). load_data_pype3 = 0. RegWrite_pype3 = RegWrite_pype2 & in_valid. stall = 0.
  - mem_op & misaligned: no request is issued. misalign_err pulses. MEM/WB gets a bubble (RegWrite_pype3 = 0). stall = 0.
  - mem_op & aligned: stall = 1. The request fields (we, addr, be, wdata, lane, size, sign) are registered, and the state moves to WAIT.
- WAIT:
  - dmem_req = 1 and all request fields are held stable.
  - stall = !dmem_ack.
  - On dmem_ack: MEM/WB captures the stage outputs and the state returns to IDLE. For a load, load_data_pype3 = extract(rdata). For a store, load_data_pype3 = 0 and RegWrite_pype3 = RegWrite_pype2.
  - The upstream stage advances on the same edge as the ack.
  - Minimum memory-op latency is 2 cycles.
  - The counter increments on every WAIT cycle without ack. When it reaches TIMEOUT_CYC: dmem_req drops, bus_err pulses, MEM/WB gets a bubble, the state returns to IDLE, and the counter clears.
- Lanes (ofs = addr[1:0]):
  - Byte: be = 0001 << ofs; wdata = {4{wd[7:0]}}.
  - Half: be = 0011 << ofs; wdata = {2{wd[15:0]}}.
  - Word: be = 1111; wdata = wd.
- Extraction:
  - Select the byte or half at ofs*8.
  - Sign-extend when funct3[2] = 0, zero-extend when funct3[2] = 1.
  - Word loads pass through unchanged.
- Inputs are sampled only in IDLE. Input changes during WAIT are ignored.
- dmem_ack while in IDLE is ignored.

Decomposition:
- mem_pkg holds:
  - MemRW encodings (MEMRW_NONE/LOAD/STORE).
  - DSIZE_B/H/W.
  - The state enum.
  - A TIMEOUT counter-width function, $clog2(TIMEOUT_CYC+1).
- One sub-module, load_extract: combinational rdata, ofs, size, unsigned → 32-bit result. It is reused by the forwarding path.

Test Plan:
- SW 0xDEADBEEF to 0x100, ack on the 2nd WAIT cycle → req for 2 cycles, addr 0x100, be 1111, wdata 0xDEADBEEF, stall high for 2 cycles, RegWrite_pype3 = 0.
- SB 0x000000AB to 0x103, immediate ack → be 1000, dmem_addr 0x100, wdata 0xABABABAB; accepted 2 cycles after presentation.
- LB from 0x102 with rdata 0x00800000 → load_data_pype3 0xFFFFFF80. LBU (funct3 100) → 0x00000080. LH from 0x102 with rdata 0x80010000 → 0xFFFF8001.
- LW at 0x101 → no dmem_req, misalign_err pulses once, RegWrite_pype3 = 0, stall stays 0.
- Load with no ack → req high for exactly 16 cycles, then bus_err pulses once, RegWrite_pype3 = 0, and the state returns to IDLE.
- ADD result 0x1234 with WReg 5, plus rst asserted during a WAIT:
  - ADD → ALU_co_pype3 = 0x1234, WReg_pype3 = 5 after 1 cycle, stall = 0.
  - rst during WAIT → req drops the next cycle, all outputs 0, no writeback.
